fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the 64-word, combinational-read instruction memory.
- Owns the PC and drives the 6-bit word address to the memory. Captures the returned 32-bit word into an IF/ID register, which is offered to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute.
- Stops fetching on ECALL/EBREAK or on a misaligned redirect target.

Parameters:
- XLEN, 32, PC and data width.
- IMEM_AW, 6, instruction-memory word-address width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- imem_addr  out  IMEM_AW  word address to instruction memory; equals pc[IMEM_AW+1:2]
- imem_data  in  32  instruction word at imem_addr, valid the same cycle
- redirect_valid  in  1  execute requests a PC change this cycle
- redirect_pc  in  XLEN  byte target of the redirect
- id_ready  in  1  decode accepts the IF/ID contents this cycle
- if_valid  out  1  IF/ID register holds a live instruction
- if_instr  out  32  fetched instruction
- if_pc  out  XLEN  byte address of if_instr
- halted  out  1  fetch stopped on ECALL (32'h00000073) or EBREAK (32'h00100073)
- fault  out  1  misaligned redirect target
- fault_pc  out  XLEN  offending redirect_pc
- fetch_count  out  32  instructions handed to decode (if_valid && id_ready)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a rising edge):
  - pc=RESET_PC, state=RUN.
  - if_valid=0, if_instr=32'h00000013 (NOP), if_pc=0.
  - halted=0, fault=0, fault_pc=0, fetch_count=0.
  - Reset overrides every other input, including mid-stall, mid-halt and mid-fault.
- States: RUN, HALTED, FAULT. halted=(state==HALTED); fault=(state==FAULT).
- Definitions: accept = if_valid && id_ready; slot_free = !if_valid || id_ready.
- Per-cycle priority, highest first: reset > redirect > capture > hold.
- Redirect (redirect_valid=1):
  - In RUN or HALTED: IF/ID is flushed (if_valid<=0) and the wrong-path slot is discarded whether or not id_ready is high.
    - redirect_pc[1:0]==0: pc<=redirect_pc, state<=RUN. A redirect cancels a wrong-path halt.
    - redirect_pc[1:0]!=0: state<=FAULT, fault_pc<=redirect_pc, pc unchanged.
  - In FAULT: ignored.
- Capture (RUN, no redirect, slot_free):
  - if_instr<=imem_data, if_pc<=pc, if_valid<=1.
  - imem_data is ECALL or EBREAK: pc holds, state<=HALTED. The halting instruction itself is still passed to decode.
  - Otherwise: pc<=pc+4, wrapping modulo 2^XLEN.
- Hold (RUN, !slot_free): pc, if_* unchanged.
- HALTED or FAULT, no redirect: pc frozen and no new capture. if_valid<=0 once accept occurs.
- fetch_count increments on accept, including in the accept cycle of a redirect. It wraps at 2^32.
- Latency: one cycle from pc to if_valid. Sustained throughput is 1 instruction/cycle while id_ready=1.
- Addressing: imem_addr uses pc[7:2] only, so PCs at or above 256 wrap into the 64-word memory without a flag.
- Back-to-back redirects: the last one wins each cycle, and no capture happens in any redirect cycle.

Decomposition:
- Shared package fetch_pkg holds:
  - the state enum {RUN, HALTED, FAULT};
  - constants NOP_INSTR=32'h00000013, ECALL_INSTR=32'h00000073, EBREAK_INSTR=32'h00100073;
  - RESET_PC default.
- One sub-module is natural: if_id_reg, the valid/ready pipeline register holding if_valid/if_instr/if_pc with load and flush inputs.

Test Plan:
- Sequential fetch: reset, memory word0=32'h00002283, word1=32'h00402b03, word2=32'h00802b83, id_ready=1 → if_pc 0,4,8 on consecutive cycles with matching if_instr; fetch_count=3 after third accept.
- Backpressure: id_ready=0 for 3 cycles with if_pc=4 held → if_instr stays 32'h00402b03, pc stays 8, fetch_count unchanged; first cycle with id_ready=1 → if_pc=8 next.
- Redirect: redirect_valid=1, redirect_pc=32'h30 while if_valid=1, id_ready=0 → next cycle if_valid=0; following cycle if_pc=32'h30, if_instr=word12 (32'h001b0b13).
- Halt: redirect to 32'hD4 where word53=32'h00000073 → if_instr=32'h00000073 valid, halted=1, pc stays 32'hD4, no further valid after accept. A subsequent redirect to 32'h0 → halted=0, fetch resumes at word0.
- Fault: redirect_pc=32'h32 → fault=1, fault_pc=32'h32, if_valid=0. A later redirect to 32'h0 is ignored; rst_n=0 for one cycle clears fault and restarts at pc 0.
- Reset mid-stream: assert rst_n=0 while if_valid=1 and pc=32'h1C → next cycle if_valid=0, pc=0, fetch_count=0, imem_addr=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// No logic: state encoding, well-known instruction words and the default reset PC.
package fetch_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      HALTED = 2'd1,
      FAULT  = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
   localparam logic [31:0] ECALL_INSTR  = 32'h0000_0073;
   localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   function automatic logic is_halt_instr(input logic [31:0] instr);
      return (instr == ECALL_INSTR) || (instr == EBREAK_INSTR);
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load beats consume; one cycle from load to valid.
// Backpressure: contents hold while valid and not consumed; the parent only loads when the slot is free.
module if_id_reg
   import fetch_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            flush,
   input  logic            consume,
   input  logic [31:0]     ld_instr,
   input  logic [XLEN-1:0] ld_pc,
   output logic            valid,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] pc
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid <= 1'b0;
         instr <= NOP_INSTR;
         pc    <= '0;
      end else if (flush) begin
         // Wrong-path contents are dropped; only the valid bit matters afterwards.
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         instr <= ld_instr;
         pc    <= ld_pc;
      end else if (consume) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, reads the 64-word imem combinationally, one cycle to if_valid.
// Backpressure: stalls (PC and IF/ID hold) while if_valid && !id_ready; stops on ECALL/EBREAK or misaligned redirect.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              IMEM_AW  = 6,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_data,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_pc,
   input  logic               id_ready,
   output logic               if_valid,
   output logic [31:0]        if_instr,
   output logic [XLEN-1:0]    if_pc,
   output logic               halted,
   output logic               fault,
   output logic [XLEN-1:0]    fault_pc,
   output logic [31:0]        fetch_count
);

   fetch_state_t    state;
   logic [XLEN-1:0] pc;
   logic            accept;
   logic            slot_free;
   logic            redir_take;
   logic            capture;

   assign imem_addr  = pc[IMEM_AW+1:2];
   assign accept     = if_valid && id_ready;
   assign slot_free  = !if_valid || id_ready;
   assign redir_take = redirect_valid && (state != FAULT);
   assign capture    = (state == RUN) && !redirect_valid && slot_free;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= RUN;
         pc       <= RESET_PC;
         halted   <= 1'b0;
         fault    <= 1'b0;
         fault_pc <= '0;
      end else if (redir_take) begin
         if (redirect_pc[1:0] == 2'b00) begin
            // A taken redirect also cancels a halt fetched on the wrong path.
            state  <= RUN;
            pc     <= redirect_pc;
            halted <= 1'b0;
         end else begin
            state    <= FAULT;
            halted   <= 1'b0;
            fault    <= 1'b1;
            fault_pc <= redirect_pc;
         end
      end else if (capture) begin
         if (is_halt_instr(imem_data)) begin
            state  <= HALTED;
            halted <= 1'b1;
         end else begin
            pc <= pc + XLEN'(4);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_count <= '0;
      end else if (accept) begin
         fetch_count <= fetch_count + 32'd1;
      end
   end

   if_id_reg #(
      .XLEN (XLEN)
   ) u_if_id_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (capture),
      .flush    (redir_take),
      .consume  (accept),
      .ld_instr (imem_data),
      .ld_pc    (pc),
      .valid    (if_valid),
      .instr    (if_instr),
      .pc       (if_pc)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed walk through the fetch scenarios followed by randomized traffic, all checked
// against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_ready;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        halted;
   logic        fault;
   logic [31:0] fault_pc;
   logic [31:0] fetch_count;

   logic [31:0] mem [64];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign imem_data = mem[imem_addr];

   fetch_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_ready       (id_ready),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .halted         (halted),
      .fault          (fault),
      .fault_pc       (fault_pc),
      .fetch_count    (fetch_count)
   );

   // Reference model: architectural fetch state in plain variables.
   localparam int M_RUN = 0, M_HALT = 1, M_FAULT = 2;
   int          m_st;
   logic [31:0] m_pc, m_instr, m_ifpc, m_fpc, m_cnt;
   logic        m_valid;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_tick();
      logic [31:0] word;
      logic        taken;
      if (!rst_n) begin
         m_st = M_RUN; m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h13;
         m_ifpc = 32'h0; m_fpc = 32'h0; m_cnt = 32'h0;
         return;
      end
      taken = m_valid && id_ready;
      if (taken) m_cnt = m_cnt + 1;
      if (redirect_valid && m_st != M_FAULT) begin
         m_valid = 1'b0;
         if (redirect_pc % 4 == 0) begin
            m_pc = redirect_pc;
            m_st = M_RUN;
         end else begin
            m_st  = M_FAULT;
            m_fpc = redirect_pc;
         end
      end else if (m_st == M_RUN && (!m_valid || id_ready)) begin
         word    = mem[(m_pc / 4) % 64];
         m_instr = word;
         m_ifpc  = m_pc;
         m_valid = 1'b1;
         if (word == 32'h73 || word == 32'h0010_0073) m_st = M_HALT;
         else m_pc = m_pc + 4;
      end else if (taken) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic compare_all();
      chk("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
      chk("if_instr", if_instr, m_instr);
      chk("if_pc", if_pc, m_ifpc);
      chk("halted", {31'b0, halted}, (m_st == M_HALT) ? 32'd1 : 32'd0);
      chk("fault", {31'b0, fault}, (m_st == M_FAULT) ? 32'd1 : 32'd0);
      chk("fault_pc", fault_pc, m_fpc);
      chk("fetch_count", fetch_count, m_cnt);
      chk("imem_addr", {26'b0, imem_addr}, (m_pc / 4) % 64);
   endtask

   task automatic step();
      model_tick();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic set_in(input logic rst, input logic rv, input logic [31:0] rp, input logic rdy);
      rst_n = rst; redirect_valid = rv; redirect_pc = rp; id_ready = rdy;
   endtask

   initial begin
      logic [31:0] rp;
      for (int i = 0; i < 64; i++) mem[i] = $urandom | 32'h4;
      mem[0]  = 32'h0000_2283;
      mem[1]  = 32'h0040_2b03;
      mem[2]  = 32'h0080_2b83;
      mem[12] = 32'h001b_0b13;
      mem[40] = 32'h0010_0073;
      mem[53] = 32'h0000_0073;

      // Reset
      set_in(1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      step(); step();
      chk("reset_nop", if_instr, 32'h0000_0013);
      chk("reset_valid", {31'b0, if_valid}, 32'd0);

      // Sequential fetch
      set_in(1'b1, 1'b0, 32'h0, 1'b1);
      step();
      chk("seq_pc0", if_pc, 32'h0);
      chk("seq_instr0", if_instr, 32'h0000_2283);
      step();
      chk("seq_pc4", if_pc, 32'h4);

      // Backpressure with if_pc=4 held
      id_ready = 1'b0;
      repeat (3) step();
      chk("bp_instr", if_instr, 32'h0040_2b03);
      chk("bp_addr", {26'b0, imem_addr}, 32'd2);
      chk("bp_cnt", fetch_count, 32'd1);
      id_ready = 1'b1;
      step();
      chk("bp_release_pc", if_pc, 32'h8);
      step();
      chk("seq_cnt3", fetch_count, 32'd3);

      // Redirect while stalled
      set_in(1'b1, 1'b1, 32'h30, 1'b0);
      step();
      chk("redir_flush", {31'b0, if_valid}, 32'd0);
      set_in(1'b1, 1'b0, 32'h0, 1'b1);
      step();
      chk("redir_pc", if_pc, 32'h30);
      chk("redir_instr", if_instr, 32'h001b_0b13);

      // Halt on ECALL, then resume via redirect
      set_in(1'b1, 1'b1, 32'hD4, 1'b0);
      step();
      set_in(1'b1, 1'b0, 32'h0, 1'b0);
      step();
      chk("halt_instr", if_instr, 32'h0000_0073);
      chk("halt_flag", {31'b0, halted}, 32'd1);
      id_ready = 1'b1;
      repeat (3) step();
      chk("halt_drained", {31'b0, if_valid}, 32'd0);
      chk("halt_addr", {26'b0, imem_addr}, 32'd53);
      set_in(1'b1, 1'b1, 32'h0, 1'b1);
      step();
      chk("unhalt", {31'b0, halted}, 32'd0);
      set_in(1'b1, 1'b0, 32'h0, 1'b1);
      step();
      chk("resume_pc", if_pc, 32'h0);

      // Misaligned redirect faults; later redirect ignored; reset clears
      set_in(1'b1, 1'b1, 32'h32, 1'b1);
      step();
      chk("fault_flag", {31'b0, fault}, 32'd1);
      chk("fault_pc", fault_pc, 32'h32);
      set_in(1'b1, 1'b1, 32'h0, 1'b1);
      repeat (2) step();
      chk("fault_sticky", {31'b0, fault}, 32'd1);
      set_in(1'b0, 1'b0, 32'h0, 1'b1);
      step();
      set_in(1'b1, 1'b0, 32'h0, 1'b1);
      step();
      chk("fault_cleared", {31'b0, fault}, 32'd0);
      chk("restart_pc", if_pc, 32'h0);

      // Reset mid-stream at pc=0x1C
      repeat (6) step();
      chk("mid_addr7", {26'b0, imem_addr}, 32'd7);
      rst_n = 1'b0;
      step();
      chk("mid_valid", {31'b0, if_valid}, 32'd0);
      chk("mid_cnt", fetch_count, 32'd0);
      chk("mid_addr0", {26'b0, imem_addr}, 32'd0);

      // PC wrap modulo 2^32
      set_in(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
      step();
      set_in(1'b1, 1'b0, 32'h0, 1'b1);
      step();
      chk("wrap_top", if_pc, 32'hFFFF_FFFC);
      step();
      chk("wrap_zero", if_pc, 32'h0);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         case ($urandom_range(0, 19))
            0:       rp = {24'b0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
            1:       rp = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 4;
            2:       rp = $urandom & 32'hFFFF_FFFC;
            default: rp = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
         endcase
         set_in(($urandom_range(0, 99) != 0), ($urandom_range(0, 19) == 0), rp,
                ($urandom_range(0, 9) < 7));
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
